// File: rtl/clock_pkg.sv
// Shared types and helpers for the time-of-day / alarm slice.
//   alarm_state_t   : alarm FSM states
//   BCD_W, SEC_W    : digit and seconds widths
//   SECS_PER_MIN    : seconds in one minute
//   bcd_time_valid  : legality check for an HH:MM BCD time (00:00..23:59)
package clock_pkg;

  typedef enum logic [1:0] {
    DISARMED,
    ARMED,
    RINGING,
    SNOOZE
  } alarm_state_t;

  localparam int unsigned BCD_W        = 4;
  localparam int unsigned SEC_W        = 6;
  localparam int unsigned SECS_PER_MIN = 60;

  function automatic logic bcd_time_valid(input logic [BCD_W-1:0] h2,
                                          input logic [BCD_W-1:0] h1,
                                          input logic [BCD_W-1:0] m2,
                                          input logic [BCD_W-1:0] m1);
    return (h2 <= 4'd2) && (h1 <= 4'd9) && (m2 <= 4'd5) && (m1 <= 4'd9) &&
           ((h2 < 4'd2) || (h1 <= 4'd3));
  endfunction

endpackage

// File: rtl/alarm_ctrl_if.sv
// User-interface bundle of the alarm controller: alarm programming and
// control pulses toward the controller, status back to the display layer.
//   master : UI / display side (drives controls, reads status)
//   slave  : alarm_ctrl side
interface alarm_ctrl_if;
  import clock_pkg::*;

  logic             set_load;
  logic [BCD_W-1:0] AH2, AH1, AM2, AM1;
  logic             arm_toggle;
  logic             snooze;
  logic             stop;

  logic             armed;
  logic             ringing;
  logic             buzzer;
  logic             set_err;
  logic [2:0]       snooze_left;
  logic [15:0]      alarm_time;

  modport master (
    output set_load, AH2, AH1, AM2, AM1, arm_toggle, snooze, stop,
    input  armed, ringing, buzzer, set_err, snooze_left, alarm_time
  );

  modport slave (
    input  set_load, AH2, AH1, AM2, AM1, arm_toggle, snooze, stop,
    output armed, ringing, buzzer, set_err, snooze_left, alarm_time
  );

endinterface

// File: rtl/alarm_time_reg.sv
// Alarm time storage with validation of the candidate digits.
//   clk, rst          : clock, async active-high reset
//   set_load          : pulse, latch candidate digits if they form a legal time
//   AH2/AH1/AM2/AM1   : candidate alarm time, BCD
//   load_ok           : combinational, set_load with legal digits (FSM uses it)
//   alarm_time        : stored {H2,H1,M2,M1}, 00:00 after reset
//   set_err           : registered one-cycle pulse after a rejected set_load
module alarm_time_reg
  import clock_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             set_load,
  input  logic [BCD_W-1:0] AH2,
  input  logic [BCD_W-1:0] AH1,
  input  logic [BCD_W-1:0] AM2,
  input  logic [BCD_W-1:0] AM1,
  output logic             load_ok,
  output logic [15:0]      alarm_time,
  output logic             set_err
);

  logic valid;

  always_comb begin
    valid   = bcd_time_valid(AH2, AH1, AM2, AM1);
    load_ok = set_load & valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_time <= '0;
      set_err    <= 1'b0;
    end else begin
      set_err <= set_load & ~valid;
      if (load_ok) alarm_time <= {AH2, AH1, AM2, AM1};
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: compares the running time against a stored alarm time
// and sequences DISARMED / ARMED / RINGING / SNOOZE, driving buzzer and
// status for the UI.
//   clk, rst        : clock, async active-high reset
//   sec_tick        : one-cycle pulse when the time inputs take a new second
//   H2,H1,M2,M1     : current time, BCD
//   Sec             : current seconds, binary 0..59
//   ui (slave)      : set_load/alarm digits/arm_toggle/snooze/stop in,
//                     armed/ringing/buzzer/set_err/snooze_left/alarm_time out
// All outputs are registered.
module alarm_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned SNOOZE_MIN     = 5,
  parameter int unsigned RING_TIMEOUT_S = 60,
  parameter int unsigned MAX_SNOOZES    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sec_tick,
  input  logic [BCD_W-1:0] H2,
  input  logic [BCD_W-1:0] H1,
  input  logic [BCD_W-1:0] M2,
  input  logic [BCD_W-1:0] M1,
  input  logic [SEC_W-1:0] Sec,
  alarm_ctrl_if.slave      ui
);

  localparam logic [11:0] SNZ_LOAD  = 12'(SNOOZE_MIN * SECS_PER_MIN);
  localparam logic [7:0]  RING_LAST = 8'(RING_TIMEOUT_S - 1);
  localparam logic [2:0]  SNZ_MAX   = 3'(MAX_SNOOZES);

  alarm_state_t state_q, state_d;
  logic [2:0]   left_q, left_d;
  logic [7:0]   ring_q, ring_d;
  logic [11:0]  snz_q, snz_d;
  logic         buzz_q, buzz_d;
  logic         armed_q, ringing_q;

  logic         load_ok;
  logic [15:0]  alarm_time;
  logic         set_err;
  logic         match;

  alarm_time_reg u_time_reg (
    .clk        (clk),
    .rst        (rst),
    .set_load   (ui.set_load),
    .AH2        (ui.AH2),
    .AH1        (ui.AH1),
    .AM2        (ui.AM2),
    .AM1        (ui.AM1),
    .load_ok    (load_ok),
    .alarm_time (alarm_time),
    .set_err    (set_err)
  );

  always_comb begin
    match = sec_tick && (Sec == '0) && ({H2, H1, M2, M1} == alarm_time);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DISARMED;
      left_q    <= SNZ_MAX;
      ring_q    <= '0;
      snz_q     <= '0;
      buzz_q    <= 1'b0;
      armed_q   <= 1'b0;
      ringing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      left_q    <= left_d;
      ring_q    <= ring_d;
      snz_q     <= snz_d;
      buzz_q    <= buzz_d;
      armed_q   <= (state_d != DISARMED);
      ringing_q <= (state_d == RINGING);
    end
  end

  // A valid set_load ranks just below arm_toggle: it pulls RINGING/SNOOZE
  // back to ARMED and in ARMED suppresses a same-cycle match (the alarm
  // time is being replaced). A rejected set_load leaves the FSM alone.
  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    ring_d  = ring_q;
    snz_d   = snz_q;
    unique case (state_q)
      DISARMED: begin
        if (ui.arm_toggle) state_d = ARMED;
      end
      ARMED: begin
        if (ui.arm_toggle) begin
          state_d = DISARMED;
        end else if (load_ok) begin
          state_d = ARMED;
        end else if (match) begin
          state_d = RINGING;
          left_d  = SNZ_MAX;
          ring_d  = '0;
        end
      end
      RINGING: begin
        if (ui.arm_toggle) begin
          state_d = DISARMED;
        end else if (load_ok || ui.stop) begin
          state_d = ARMED;
        end else if (ui.snooze) begin
          if (left_q != '0) begin
            state_d = SNOOZE;
            left_d  = left_q - 3'd1;
            snz_d   = SNZ_LOAD;
          end else begin
            state_d = ARMED;
          end
        end else if (sec_tick) begin
          if (ring_q == RING_LAST) state_d = ARMED;
          else                     ring_d  = ring_q + 8'd1;
        end
      end
      SNOOZE: begin
        if (ui.arm_toggle) begin
          state_d = DISARMED;
        end else if (load_ok || ui.stop) begin
          state_d = ARMED;
        end else if (sec_tick) begin
          snz_d = snz_q - 12'd1;
          if (snz_q == 12'd1) begin
            state_d = RINGING;
            ring_d  = '0;
          end
        end
      end
      default: state_d = DISARMED;
    endcase

    // Buzzer only runs while staying in RINGING; entry and exit force it low.
    buzz_d = ((state_q == RINGING) && (state_d == RINGING)) ? (buzz_q ^ sec_tick) : 1'b0;
  end

  assign ui.armed       = armed_q;
  assign ui.ringing     = ringing_q;
  assign ui.buzzer      = buzz_q;
  assign ui.set_err     = set_err;
  assign ui.snooze_left = left_q;
  assign ui.alarm_time  = alarm_time;

endmodule

// File: tb/tb_alarm_ctrl.sv
module tb_alarm_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sec_tick = 1'b0;
  logic [15:0] tnow = 16'h0000;
  logic [5:0]  sec = 6'd0;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  alarm_ctrl_if u_if ();

  alarm_ctrl #(
    .SNOOZE_MIN     (5),
    .RING_TIMEOUT_S (60),
    .MAX_SNOOZES    (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sec_tick (sec_tick),
    .H2       (tnow[15:12]),
    .H1       (tnow[11:8]),
    .M2       (tnow[7:4]),
    .M1       (tnow[3:0]),
    .Sec      (sec),
    .ui       (u_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [15:0] at;
    logic        arm;
    logic        snz;
    logic        stp;
    logic        tick;
    logic [15:0] t;
    logic [5:0]  s;
    logic        e_armed;
    logic        e_ring;
    logic        e_buzz;
    logic        e_err;
    logic [2:0]  e_left;
    logic [15:0] e_at;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic e_armed, input logic e_ring,
                         input logic e_buzz, input logic e_err, input logic [2:0] e_left,
                         input logic [15:0] e_at);
    chk({tag, ".armed"},       32'(u_if.armed),       32'(e_armed));
    chk({tag, ".ringing"},     32'(u_if.ringing),     32'(e_ring));
    chk({tag, ".buzzer"},      32'(u_if.buzzer),      32'(e_buzz));
    chk({tag, ".set_err"},     32'(u_if.set_err),     32'(e_err));
    chk({tag, ".snooze_left"}, 32'(u_if.snooze_left), 32'(e_left));
    chk({tag, ".alarm_time"},  32'(u_if.alarm_time),  32'(e_at));
  endtask

  // One clock: inputs already set, advance past the edge, clear pulses.
  task automatic step();
    @(posedge clk);
    #1;
    u_if.set_load   = 1'b0;
    u_if.arm_toggle = 1'b0;
    u_if.snooze     = 1'b0;
    u_if.stop       = 1'b0;
    sec_tick        = 1'b0;
  endtask

  task automatic tick(input logic [15:0] t, input logic [5:0] s);
    tnow = t;
    sec = s;
    sec_tick = 1'b1;
    step();
  endtask

  task automatic load(input logic [15:0] a);
    {u_if.AH2, u_if.AH1, u_if.AM2, u_if.AM1} = a;
    u_if.set_load = 1'b1;
    step();
  endtask

  task automatic pulse(input logic arm, input logic snz, input logic stp);
    u_if.arm_toggle = arm;
    u_if.snooze = snz;
    u_if.stop = stp;
    step();
  endtask

  initial begin
    u_if.set_load = 1'b0;
    {u_if.AH2, u_if.AH1, u_if.AM2, u_if.AM1} = 16'h0000;
    u_if.arm_toggle = 1'b0;
    u_if.snooze = 1'b0;
    u_if.stop = 1'b0;

    //           ld  at       arm  snz  stp  tk   t        s      arm rng bz err left at
    vecs[0]  = '{1, 16'h0730, 0,   0,   0,   0,   16'h0000, 6'd0,  0,  0,  0, 0,  3, 16'h0730};
    vecs[1]  = '{1, 16'h2400, 0,   0,   0,   0,   16'h0000, 6'd0,  0,  0,  0, 1,  3, 16'h0730};
    vecs[2]  = '{1, 16'h1360, 0,   0,   0,   0,   16'h0000, 6'd0,  0,  0,  0, 1,  3, 16'h0730};
    vecs[3]  = '{0, 16'h0000, 0,   0,   0,   0,   16'h0000, 6'd0,  0,  0,  0, 0,  3, 16'h0730};
    vecs[4]  = '{0, 16'h0000, 1,   0,   0,   0,   16'h0000, 6'd0,  1,  0,  0, 0,  3, 16'h0730};
    vecs[5]  = '{0, 16'h0000, 0,   0,   0,   1,   16'h0729, 6'd59, 1,  0,  0, 0,  3, 16'h0730};
    vecs[6]  = '{0, 16'h0000, 0,   0,   0,   1,   16'h0730, 6'd0,  1,  1,  0, 0,  3, 16'h0730};
    vecs[7]  = '{0, 16'h0000, 0,   0,   0,   1,   16'h0730, 6'd1,  1,  1,  1, 0,  3, 16'h0730};
    vecs[8]  = '{0, 16'h0000, 0,   0,   0,   1,   16'h0730, 6'd2,  1,  1,  0, 0,  3, 16'h0730};
    vecs[9]  = '{0, 16'h0000, 0,   1,   0,   0,   16'h0730, 6'd2,  1,  0,  0, 0,  2, 16'h0730};
    vecs[10] = '{0, 16'h0000, 0,   1,   0,   0,   16'h0730, 6'd2,  1,  0,  0, 0,  2, 16'h0730};
    vecs[11] = '{0, 16'h0000, 0,   0,   1,   0,   16'h0730, 6'd2,  1,  0,  0, 0,  2, 16'h0730};
    vecs[12] = '{1, 16'h2359, 0,   0,   0,   0,   16'h0730, 6'd2,  1,  0,  0, 0,  2, 16'h2359};
    vecs[13] = '{0, 16'h0000, 1,   0,   0,   0,   16'h0730, 6'd2,  0,  0,  0, 0,  2, 16'h2359};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 3'd3, 16'h0000);
    rst = 1'b0;

    // Table-driven single-cycle vectors
    for (int i = 0; i < 14; i++) begin
      u_if.set_load = vecs[i].ld;
      {u_if.AH2, u_if.AH1, u_if.AM2, u_if.AM1} = vecs[i].at;
      u_if.arm_toggle = vecs[i].arm;
      u_if.snooze = vecs[i].snz;
      u_if.stop = vecs[i].stp;
      sec_tick = vecs[i].tick;
      tnow = vecs[i].t;
      sec = vecs[i].s;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_armed, vecs[i].e_ring, vecs[i].e_buzz,
              vecs[i].e_err, vecs[i].e_left, vecs[i].e_at);
    end

    // Full ring with timeout after 60 unanswered ticks
    load(16'h0730);
    chk("A.load", 32'(u_if.alarm_time), 32'h0730);
    pulse(1, 0, 0);
    tick(16'h0729, 6'd59);
    chk("A.preringing", 32'(u_if.ringing), 32'd0);
    tick(16'h0730, 6'd0);
    chk("A.ringing", 32'(u_if.ringing), 32'd1);
    chk("A.left_reload", 32'(u_if.snooze_left), 32'd3);
    chk("A.buzz_entry", 32'(u_if.buzzer), 32'd0);
    for (int k = 1; k < 60; k++) begin
      tick(16'h0731, 6'(k));
      chk($sformatf("A.ring%0d", k), 32'(u_if.ringing), 32'd1);
      chk($sformatf("A.buzz%0d", k), 32'(u_if.buzzer), 32'(k % 2));
    end
    tick(16'h0732, 6'd0);
    chk("A.timeout_ring", 32'(u_if.ringing), 32'd0);
    chk("A.timeout_armed", 32'(u_if.armed), 32'd1);
    chk("A.timeout_buzz", 32'(u_if.buzzer), 32'd0);

    // Three snoozes, each re-ringing after 300 ticks, then a fourth dismisses
    tick(16'h0730, 6'd0);
    chk("B.ringing", 32'(u_if.ringing), 32'd1);
    for (int n = 1; n <= 3; n++) begin
      pulse(0, 1, 0);
      chk($sformatf("B.left%0d", n), 32'(u_if.snooze_left), 32'(3 - n));
      chk($sformatf("B.quiet%0d", n), 32'(u_if.ringing), 32'd0);
      for (int k = 0; k < 299; k++) tick(16'h0740, 6'd1);
      chk($sformatf("B.still_quiet%0d", n), 32'(u_if.ringing), 32'd0);
      tick(16'h0740, 6'd1);
      chk($sformatf("B.rering%0d", n), 32'(u_if.ringing), 32'd1);
      chk($sformatf("B.rering_buzz%0d", n), 32'(u_if.buzzer), 32'd0);
    end
    pulse(0, 1, 0);
    chk("B.fourth_ring", 32'(u_if.ringing), 32'd0);
    chk("B.fourth_armed", 32'(u_if.armed), 32'd1);
    chk("B.fourth_left", 32'(u_if.snooze_left), 32'd0);

    // Simultaneous pulses in RINGING
    tick(16'h0730, 6'd0);
    chk("C.ringing", 32'(u_if.ringing), 32'd1);
    pulse(0, 1, 1);
    chk("C.stopsnz_ring", 32'(u_if.ringing), 32'd0);
    chk("C.stopsnz_armed", 32'(u_if.armed), 32'd1);
    chk("C.stopsnz_left", 32'(u_if.snooze_left), 32'd3);
    tick(16'h0730, 6'd0);
    chk("C.ringing2", 32'(u_if.ringing), 32'd1);
    pulse(1, 0, 1);
    chk("C.armstop_armed", 32'(u_if.armed), 32'd0);
    chk("C.armstop_ring", 32'(u_if.ringing), 32'd0);

    // Loading the current time mid-minute does not ring until next Sec==0 match
    pulse(1, 0, 0);
    chk("D.armed", 32'(u_if.armed), 32'd1);
    tick(16'h0845, 6'd30);
    load(16'h0845);
    chk("D.load", 32'(u_if.alarm_time), 32'h0845);
    chk("D.noring1", 32'(u_if.ringing), 32'd0);
    tick(16'h0845, 6'd31);
    chk("D.noring2", 32'(u_if.ringing), 32'd0);
    tick(16'h0846, 6'd0);
    chk("D.noring3", 32'(u_if.ringing), 32'd0);
    tick(16'h0845, 6'd0);
    chk("D.ring", 32'(u_if.ringing), 32'd1);

    // Asynchronous reset while ringing with buzzer high
    tick(16'h0845, 6'd1);
    chk("E.buzz_high", 32'(u_if.buzzer), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_all("E.reset", 0, 0, 0, 0, 3'd3, 16'h0000);
    #2 rst = 1'b0;
    step();
    chk("E.after_armed", 32'(u_if.armed), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
- Downstream consumer of the time-of-day counter: takes its BCD digits (H2 H1 : M2 M1) and 6-bit seconds, plus a one-cycle seconds tick.
- Holds a user-programmed alarm time and runs a disarmed/armed/ringing/snooze state machine.
- Drives the buzzer and status outputs for the display/UI layer.

Parameters:
- SNOOZE_MIN, 5, snooze length in minutes, range 1..59.
- RING_TIMEOUT_S, 60, seconds of unanswered ringing before auto-silence, range 1..255.
- MAX_SNOOZES, 3, snoozes allowed per alarm event, range 1..7.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- sec_tick  in  1  one-cycle pulse in the cycle the time inputs take a new second's value
- H2, H1, M2, M1  in  4 each  current time, BCD
- Sec  in  6  current seconds, binary 0..59
- set_load  in  1  pulse: latch AH2/AH1/AM2/AM1 as the alarm time
- AH2, AH1, AM2, AM1  in  4 each  candidate alarm time, BCD
- arm_toggle  in  1  pulse: toggle armed/disarmed
- snooze  in  1  pulse: snooze request
- stop  in  1  pulse: dismiss alarm
- armed  out  1  1 in ARMED, RINGING or SNOOZE
- ringing  out  1  1 in RINGING
- buzzer  out  1  square wave while ringing
- set_err  out  1  one-cycle pulse on a rejected set_load
- snooze_left  out  3  snoozes remaining for the current event
- alarm_time  out  16  latched alarm {H2,H1,M2,M1}

Behaviour:
- Reset (async):
  - State DISARMED; alarm_time 16'h0000 (00:00).
  - ringing, buzzer, set_err = 0; snooze_left = MAX_SNOOZES.
  - Internal counters = 0.
- States and transitions, priority top to bottom within each state:
  - DISARMED:
    - arm_toggle -> ARMED.
  - ARMED:
    - arm_toggle -> DISARMED.
    - Otherwise, match -> RINGING.
    - match = sec_tick & Sec==0 & {H2,H1,M2,M1}==alarm_time.
    - On entry from a match: snooze_left reloads MAX_SNOOZES; ring counter clears.
  - RINGING:
    - arm_toggle -> DISARMED.
    - Else stop -> ARMED.
    - Else snooze with snooze_left>0 -> SNOOZE, snooze_left decrements, snooze counter loads SNOOZE_MIN*60.
    - Else snooze with snooze_left==0 -> ARMED (treated as stop).
    - Else sec_tick with ring counter == RING_TIMEOUT_S-1 -> ARMED. Otherwise sec_tick increments the ring counter.
  - SNOOZE:
    - arm_toggle -> DISARMED.
    - Else stop -> ARMED.
    - Else sec_tick decrements the snooze counter; at 1 -> RINGING, ring counter clears.
    - snooze pulses are ignored.
- Simultaneous events:
  - arm_toggle beats stop; stop beats snooze; stop/snooze beat a same-cycle timeout or match.
- buzzer:
  - Forced 0 outside RINGING and on RINGING entry.
  - Toggles on every sec_tick while in RINGING.
- set_load:
  - Valid when AH2<=2, AH1<=9, AM2<=5, AM1<=9, and (AH2<2 or AH1<=3).
  - Valid: alarm_time updates next edge. If the state is RINGING or SNOOZE, it moves to ARMED; state is otherwise unchanged.
  - Invalid: alarm_time unchanged; set_err high exactly one cycle.
  - set_load takes precedence over stop/snooze in the same cycle; arm_toggle is still applied.
- Match is evaluated only in ARMED, so a loaded time equal to the current time rings only at the next Sec==0 tick.
- Latency: every output is registered; ringing rises in the cycle after the matching sec_tick.
- Width rules:
  - Snooze counter 12 bits (max 3540).
  - Ring counter 8 bits.
  - No wrap: counters are reloaded or cleared on state entry.
- Inputs are not range-checked (the upstream counter guarantees legality); only the alarm digits are validated.

Decomposition:
- Shared package clock_pkg:
  - state enum (DISARMED, ARMED, RINGING, SNOOZE);
  - BCD digit width 4;
  - SEC_W 6;
  - constant SECS_PER_MIN 60;
  - function bcd_time_valid(h2,h1,m2,m1).
- One natural sub-module, alarm_time_reg: validation plus alarm storage, producing alarm_time and set_err.
- The FSM and counters stay in alarm_ctrl.

Test Plan:
- Reset mid-RINGING -> same cycle: ringing=0, buzzer=0, armed=0, alarm_time=0000, snooze_left=3.
- set_load 07:30, arm, drive time 07:29:59 then tick to 07:30:00 -> ringing=1 next cycle. buzzer toggles on each later tick; after 60 ticks, ringing=0 and armed=1.
- Ringing, snooze x3 each followed by 300 ticks -> re-rings each time, snooze_left 2,1,0. Fourth snooze -> ARMED, ringing=0.
- set_load 24:00 and 13:60 -> set_err one-cycle pulse each, alarm_time unchanged. set_load 23:59 -> accepted, set_err=0.
- Same cycle in RINGING: stop+snooze -> ARMED, snooze_left unchanged. arm_toggle+stop -> DISARMED.
- Armed, time 07:30:00 to 07:30:00 without Sec==0 re-entry, plus set_load to the current time at Sec=30 -> no ring until the next matching Sec==0 tick.
